// File: rtl/commit_tracer_if.sv
// Bundles the write-back observation inputs, the retirement record stream and
// the event counters between the pipeline/consumer side and the commit tracer.
interface commit_tracer_if #(
    parameter int CNT_W = 32
);
    logic             enable;
    logic             wb_valid;
    logic [31:0]      wb_pc;
    logic             wb_reg_write;
    logic [4:0]       wb_rd;
    logic [31:0]      wb_data;
    logic             wb_store;
    logic             stall;
    logic             flush;

    logic             rec_valid;
    logic             rec_ready;
    logic [31:0]      rec_pc;
    logic [4:0]       rec_rd;
    logic [31:0]      rec_data;
    logic [1:0]       rec_kind;

    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] retire_count;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
    logic [CNT_W-1:0] drop_count;
    logic             overflow;

    modport master (
        output enable, wb_valid, wb_pc, wb_reg_write, wb_rd, wb_data, wb_store,
               stall, flush, rec_ready,
        input  rec_valid, rec_pc, rec_rd, rec_data, rec_kind,
               cycle_count, retire_count, stall_count, flush_count, drop_count,
               overflow
    );

    modport slave (
        input  enable, wb_valid, wb_pc, wb_reg_write, wb_rd, wb_data, wb_store,
               stall, flush, rec_ready,
        output rec_valid, rec_pc, rec_rd, rec_data, rec_kind,
               cycle_count, retire_count, stall_count, flush_count, drop_count,
               overflow
    );
endinterface

// File: rtl/commit_tracer.sv
// Commit tracer: queues one record per retired instruction in a small FIFO and
// keeps saturating event counters for cycles, retirements, stalls, flushes and drops.
module commit_tracer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic            clock,
    input  logic            reset,
    commit_tracer_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] KIND_REG   = 2'd0;
    localparam logic [1:0] KIND_STORE = 2'd1;
    localparam logic [1:0] KIND_NONE  = 2'd2;

    logic [31:0]      pcMem_q   [DEPTH];
    logic [4:0]       rdMem_q   [DEPTH];
    logic [31:0]      dataMem_q [DEPTH];
    logic [1:0]       kindMem_q [DEPTH];

    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;

    logic [CNT_W-1:0] cycleCnt_q, retireCnt_q, stallCnt_q, flushCnt_q, dropCnt_q;
    logic             overflow_q;

    logic             pushAttempt, doPush, doPop, doDrop, full, notEmpty;
    logic [4:0]       recRd_d;
    logic [1:0]       recKind_d;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    assign notEmpty    = (count_q != '0);
    assign full        = (count_q == (AW+1)'(DEPTH));
    assign pushAttempt = bus.enable && bus.wb_valid;
    assign doPop       = notEmpty && bus.rec_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign doPush      = pushAttempt && (!full || doPop);
    assign doDrop      = pushAttempt && full && !doPop;

    always_comb begin
        recRd_d   = 5'd0;
        recKind_d = KIND_NONE;
        if (bus.wb_store) begin
            recKind_d = KIND_STORE;
        end else if (bus.wb_reg_write && (bus.wb_rd != 5'd0)) begin
            recKind_d = KIND_REG;
            recRd_d   = bus.wb_rd;
        end
    end

    always_comb begin
        wptr_d  = doPush ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = doPop  ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q + (AW+1)'(doPush) - (AW+1)'(doPop);
    end

    always_ff @(posedge clock) begin
        if (doPush) begin
            pcMem_q[wptr_q]   <= bus.wb_pc;
            rdMem_q[wptr_q]   <= recRd_d;
            dataMem_q[wptr_q] <= bus.wb_data;
            kindMem_q[wptr_q] <= recKind_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycleCnt_q  <= '0;
            retireCnt_q <= '0;
            stallCnt_q  <= '0;
            flushCnt_q  <= '0;
            dropCnt_q   <= '0;
            overflow_q  <= 1'b0;
        end else if (bus.enable) begin
            cycleCnt_q <= satInc(cycleCnt_q);
            if (bus.wb_valid) retireCnt_q <= satInc(retireCnt_q);
            if (bus.stall)    stallCnt_q  <= satInc(stallCnt_q);
            if (bus.flush)    flushCnt_q  <= satInc(flushCnt_q);
            if (doDrop) begin
                dropCnt_q  <= satInc(dropCnt_q);
                overflow_q <= 1'b1;
            end
        end
    end

    // Record fields are gated by rec_valid so reset drives them to zero at once.
    assign bus.rec_valid    = notEmpty;
    assign bus.rec_pc       = notEmpty ? pcMem_q[rptr_q]   : 32'd0;
    assign bus.rec_rd       = notEmpty ? rdMem_q[rptr_q]   : 5'd0;
    assign bus.rec_data     = notEmpty ? dataMem_q[rptr_q] : 32'd0;
    assign bus.rec_kind     = notEmpty ? kindMem_q[rptr_q] : 2'd0;

    assign bus.cycle_count  = cycleCnt_q;
    assign bus.retire_count = retireCnt_q;
    assign bus.stall_count  = stallCnt_q;
    assign bus.flush_count  = flushCnt_q;
    assign bus.drop_count   = dropCnt_q;
    assign bus.overflow     = overflow_q;
endmodule
